// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - op codes and FSM state encoding for the data memory access controller
package dm_pkg;

  localparam logic [2:0] DMI_SW = 3'd0;
  localparam logic [2:0] DMI_SB = 3'd1;
  localparam logic [2:0] DMI_SH = 3'd2;

  localparam logic [2:0] DMO_LW  = 3'd0;
  localparam logic [2:0] DMO_LBU = 3'd1;
  localparam logic [2:0] DMO_LB  = 3'd2;
  localparam logic [2:0] DMO_LHU = 3'd3;
  localparam logic [2:0] DMO_LH  = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_MERGE = ST_MERGE,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/dm_lane_fmt.sv
// rtl/dm_lane_fmt.sv - byte/halfword lane merge for stores, extract/extend for loads, alignment check
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [1:0]  a,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] wd,
  input  logic [31:0] word,
  output logic [31:0] merged,
  output logic [31:0] load_word,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{a, 3'b000} +: 8];
  assign lane_h = word[{a[1], 4'b0000} +: 16];

  always_comb begin
    merged     = wd;
    load_word  = word;
    misaligned = 1'b0;
    if (we) begin
      case (op)
        DMI_SB: begin
          merged = word;
          merged[{a, 3'b000} +: 8] = wd[7:0];
        end
        DMI_SH: begin
          merged = word;
          merged[{a[1], 4'b0000} +: 16] = wd[15:0];
          misaligned = a[0];
        end
        default: misaligned = (a != 2'b00);
      endcase
    end else begin
      case (op)
        DMO_LBU: load_word = {24'h000000, lane_b};
        DMO_LB:  load_word = {{24{lane_b[7]}}, lane_b};
        DMO_LHU: begin
          load_word  = {16'h0000, lane_h};
          misaligned = a[0];
        end
        DMO_LH: begin
          load_word  = {{16{lane_h[15]}}, lane_h};
          misaligned = a[0];
        end
        default: misaligned = (a != 2'b00);
      endcase
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - two-port round-robin sequencer for the single-port data memory
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter bit ERR_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [2:0]  Op0,
  input  logic [2:0]  Op1,
  input  logic [31:0] A0,
  input  logic [31:0] A1,
  input  logic [31:0] WD0,
  input  logic [31:0] WD1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] RD0,
  output logic [31:0] RD1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] mem_A,
  output logic        mem_RE,
  output logic        mem_WE,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  state_t      state;
  logic        last;
  logic        port;
  logic        l_we;
  logic [2:0]  l_op;
  logic [31:0] l_a;
  logic [31:0] l_wd;

  logic        any_req;
  logic        win;
  logic        w_we;
  logic [2:0]  w_op;
  logic [31:0] w_a;
  logic [31:0] w_wd;
  logic        w_sub;

  logic [1:0]  f_a;
  logic        f_we;
  logic [2:0]  f_op;
  logic [31:0] merged;
  logic [31:0] load_word;
  logic        fmt_mis;
  logic        mis;

  assign any_req = Req0 | Req1;
  assign win     = (Req0 & Req1) ? ~last : Req1;
  assign w_we    = win ? WE1 : WE0;
  assign w_op    = win ? Op1 : Op0;
  assign w_a     = win ? A1  : A0;
  assign w_wd    = win ? WD1 : WD0;
  assign w_sub   = w_we && (w_op == DMI_SB || w_op == DMI_SH);

  // In IDLE the alignment check looks at the arbitration winner; afterwards at the latched request.
  assign f_a  = (state == S_IDLE) ? w_a[1:0] : l_a[1:0];
  assign f_we = (state == S_IDLE) ? w_we     : l_we;
  assign f_op = (state == S_IDLE) ? w_op     : l_op;
  assign mis  = ERR_CHECK && fmt_mis;

  dm_lane_fmt u_fmt (
    .a          (f_a),
    .we         (f_we),
    .op         (f_op),
    .wd         (l_wd),
    .word       (mem_RD),
    .merged     (merged),
    .load_word  (load_word),
    .misaligned (fmt_mis)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      last   <= 1'b1;
      port   <= 1'b0;
      l_we   <= 1'b0;
      l_op   <= '0;
      l_a    <= '0;
      l_wd   <= '0;
      Ack0   <= 1'b0;
      Ack1   <= 1'b0;
      RD0    <= '0;
      RD1    <= '0;
      Err0   <= 1'b0;
      Err1   <= 1'b0;
      mem_A  <= '0;
      mem_RE <= 1'b0;
      mem_WE <= 1'b0;
      mem_WD <= '0;
    end else begin
      mem_RE <= 1'b0;
      mem_WE <= 1'b0;
      Ack0   <= 1'b0;
      Ack1   <= 1'b0;
      RD0    <= '0;
      RD1    <= '0;
      Err0   <= 1'b0;
      Err1   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            last <= win;
            port <= win;
            l_we <= w_we;
            l_op <= w_op;
            l_a  <= w_a;
            l_wd <= w_wd;
            if (mis) begin
              state <= S_DONE;
              Ack0  <= ~win;
              Ack1  <= win;
              Err0  <= ~win;
              Err1  <= win;
            end else begin
              mem_A <= {w_a[31:2], 2'b00};
              if (w_we && !w_sub) begin
                state  <= S_WRITE;
                mem_WE <= 1'b1;
                mem_WD <= w_wd;
              end else begin
                state  <= S_READ;
                mem_RE <= 1'b1;
              end
            end
          end
        end
        S_READ: state <= S_MERGE;
        S_MERGE: begin
          if (l_we) begin
            state  <= S_WRITE;
            mem_WE <= 1'b1;
            mem_A  <= {l_a[31:2], 2'b00};
            mem_WD <= merged;
          end else begin
            state <= S_DONE;
            Ack0  <= ~port;
            Ack1  <= port;
            if (port) RD1 <= load_word;
            else      RD0 <= load_word;
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          Ack0  <= ~port;
          Ack1  <= port;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - directed self-checking bench for dm_access_ctrl
module tb_dm_access_ctrl;
  import dm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset_n;
  logic        Req0, Req1, WE0, WE1;
  logic [2:0]  Op0, Op1;
  logic [31:0] A0, A1, WD0, WD1;
  logic        Ack0, Ack1, Err0, Err1;
  logic [31:0] RD0, RD1, mem_A, mem_WD, mem_RD;
  logic        mem_RE, mem_WE;

  logic        nc_req;
  logic [31:0] nc_a;
  logic        nc_ack0, nc_ack1, nc_err0, nc_err1;
  logic [31:0] nc_rd0, nc_rd1, nc_mem_A, nc_mem_WD, nc_mem_RD;
  logic        nc_mem_RE, nc_mem_WE;

  int n_assert = 0;
  int n_fail   = 0;

  dm_access_ctrl #(.ERR_CHECK(1'b1)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .Req0(Req0), .Req1(Req1), .WE0(WE0), .WE1(WE1), .Op0(Op0), .Op1(Op1),
    .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1),
    .Ack0(Ack0), .Ack1(Ack1), .RD0(RD0), .RD1(RD1), .Err0(Err0), .Err1(Err1),
    .mem_A(mem_A), .mem_RE(mem_RE), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  dm_access_ctrl #(.ERR_CHECK(1'b0)) dut_nc (
    .clk(clk), .Reset_n(Reset_n),
    .Req0(nc_req), .Req1(1'b0), .WE0(1'b0), .WE1(1'b0), .Op0(DMO_LW), .Op1(DMO_LW),
    .A0(nc_a), .A1(32'h0), .WD0(32'h0), .WD1(32'h0),
    .Ack0(nc_ack0), .Ack1(nc_ack1), .RD0(nc_rd0), .RD1(nc_rd1), .Err0(nc_err0), .Err1(nc_err1),
    .mem_A(nc_mem_A), .mem_RE(nc_mem_RE), .mem_WE(nc_mem_WE), .mem_WD(nc_mem_WD), .mem_RD(nc_mem_RD)
  );

  // Synchronous-read memory models plus activity monitors.
  logic [31:0] mem    [0:63];
  logic [31:0] mem_nc [0:63];
  logic        pl_we = 1'b0;
  logic [31:0] pl_a  = '0;
  logic [31:0] pl_d  = '0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  int          glog[$];
  logic [7:0]  oplog[$];

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_a[7:2]]    <= pl_d;
      mem_nc[pl_a[7:2]] <= pl_d;
    end
    if (mem_RE) begin
      mem_RD <= mem[mem_A[7:2]];
      re_cnt <= re_cnt + 1;
      oplog.push_back({1'b0, mem_A[6:0]});
    end
    if (mem_WE) begin
      mem[mem_A[7:2]] <= mem_WD;
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_A;
      last_wd <= mem_WD;
      oplog.push_back({1'b1, mem_A[6:0]});
    end
    if (nc_mem_RE) nc_mem_RD <= mem_nc[nc_mem_A[7:2]];
    if (nc_mem_WE) mem_nc[nc_mem_A[7:2]] <= nc_mem_WD;
    if (Ack0) glog.push_back(0);
    if (Ack1) glog.push_back(1);
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic txn(input bit p, input bit we, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic err);
    bit hit;
    hit = 1'b0;
    if (!p) begin Req0 = 1'b1; WE0 = we; Op0 = op; A0 = a; WD0 = wd; end
    else    begin Req1 = 1'b1; WE1 = we; Op1 = op; A1 = a; WD1 = wd; end
    lat = 0;
    while (!hit && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      hit = p ? Ack1 : Ack0;
    end
    if (!hit) begin
      n_assert++; n_fail++;
      $display("FAIL txn_timeout port%0d: Ack=0 after %0d cycles, required Ack=1", p, lat);
    end
    rd  = p ? RD1 : RD0;
    err = p ? Err1 : Err0;
    if (!p) Req0 = 1'b0; else Req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_assert++;
    if ({Ack0, Ack1, Err0, Err1, mem_RE, mem_WE} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000", {Ack0, Ack1, Err0, Err1, mem_RE, mem_WE});
    end
    n_assert++;
    if ({RD0, RD1, mem_A, mem_WD} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_buses: RD0=%h RD1=%h mem_A=%h mem_WD=%h, required all 0", RD0, RD1, mem_A, mem_WD);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_ops [9] = '{8'hC0, 8'h50, 8'hD0, 8'hC4, 8'h50, 8'hD0, 8'hC8, 8'h50, 8'hD0};
    int         exp_g [6]   = '{0, 1, 0, 1, 0, 1};
    int         base_op, base_g;
    preload(32'h50, 32'h0);
    base_op = oplog.size();
    base_g  = glog.size();
    fork
      begin : s0
        int t0;
        for (int i = 0; i < 3; i++) begin
          Req0 = 1'b1; WE0 = 1'b1; Op0 = DMI_SW; A0 = 32'h40 + 4 * i; WD0 = 32'hA000_0000 + i;
          t0 = 0;
          do begin @(posedge clk); #1; t0++; end while (!Ack0 && t0 < 30);
          if (!Ack0) begin
            n_assert++; n_fail++;
            $display("FAIL b2b_port0_timeout: Ack0=0 after %0d cycles, required Ack0=1", t0);
          end
        end
        Req0 = 1'b0;
      end
      begin : s1
        int t1;
        for (int i = 0; i < 3; i++) begin
          Req1 = 1'b1; WE1 = 1'b1; Op1 = DMI_SB; A1 = 32'h50 + i; WD1 = 32'hB0 + i;
          t1 = 0;
          do begin @(posedge clk); #1; t1++; end while (!Ack1 && t1 < 30);
          if (!Ack1) begin
            n_assert++; n_fail++;
            $display("FAIL b2b_port1_timeout: Ack1=0 after %0d cycles, required Ack1=1", t1);
          end
        end
        Req1 = 1'b0;
      end
    join
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      n_assert++;
      if (glog[base_g + i] !== exp_g[i]) begin
        n_fail++;
        $display("FAIL b2b_grant[%0d]: got port %0d, required port %0d", i, glog[base_g + i], exp_g[i]);
      end
    end
    for (int i = 0; i < 9; i++) begin
      n_assert++;
      if (oplog[base_op + i] !== exp_ops[i]) begin
        n_fail++;
        $display("FAIL b2b_memop[%0d]: got %h, required %h", i, oplog[base_op + i], exp_ops[i]);
      end
    end
    n_assert++;
    if (mem[20] !== 32'h00B2_B1B0) begin
      n_fail++;
      $display("FAIL b2b_sb_word: got %h, required 00b2b1b0", mem[20]);
    end
    n_assert++;
    if ({mem[16], mem[17], mem[18]} !== {32'hA000_0000, 32'hA000_0001, 32'hA000_0002}) begin
      n_fail++;
      $display("FAIL b2b_sw_words: got %h %h %h, required a0000000 a0000001 a0000002", mem[16], mem[17], mem[18]);
    end
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd; logic err; int base_we;
    base_we = we_cnt;
    txn(1'b0, 1'b1, DMI_SW, 32'h10, 32'hDEAD_BEEF, lat, rd, err);
    n_assert++;
    if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d, required 2", lat); end
    n_assert++;
    if ({we_cnt - base_we, last_wa, last_wd} !== {32'd1, 32'h10, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL sw_write: pulses=%0d addr=%h data=%h, required 1 00000010 deadbeef", we_cnt - base_we, last_wa, last_wd);
    end
    txn(1'b0, 1'b0, DMO_LW, 32'h10, 32'h0, lat, rd, err);
    n_assert++;
    if ({lat, rd, err} !== {32'd3, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_result: lat=%0d rd=%h err=%b, required 3 deadbeef 0", lat, rd, err);
    end
  endtask

  task automatic test_sub_byte();
    int lat; logic [31:0] rd; logic err;
    preload(32'h20, 32'h1122_3344);
    txn(1'b0, 1'b1, DMI_SB, 32'h22, 32'h0000_00AA, lat, rd, err);
    n_assert++;
    if ({lat, last_wd, mem[8]} !== {32'd4, 32'h11AA_3344, 32'h11AA_3344}) begin
      n_fail++;
      $display("FAIL sb_rmw: lat=%0d mem_WD=%h word=%h, required 4 11aa3344 11aa3344", lat, last_wd, mem[8]);
    end
    txn(1'b1, 1'b0, DMO_LB, 32'h22, 32'h0, lat, rd, err);
    n_assert++;
    if ({lat, rd} !== {32'd3, 32'hFFFF_FFAA}) begin
      n_fail++;
      $display("FAIL lb_sext: lat=%0d rd=%h, required 3 ffffffaa", lat, rd);
    end
    txn(1'b0, 1'b0, DMO_LBU, 32'h22, 32'h0, lat, rd, err);
    n_assert++;
    if (rd !== 32'h0000_00AA) begin n_fail++; $display("FAIL lbu_zext: got %h, required 000000aa", rd); end
  endtask

  task automatic test_halfword();
    int lat; logic [31:0] rd; logic err;
    preload(32'h30, 32'h8001_7FFF);
    txn(1'b1, 1'b0, DMO_LH, 32'h32, 32'h0, lat, rd, err);
    n_assert++;
    if (rd !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_sext: got %h, required ffff8001", rd); end
    txn(1'b0, 1'b0, DMO_LHU, 32'h32, 32'h0, lat, rd, err);
    n_assert++;
    if (rd !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_zext: got %h, required 00008001", rd); end
    txn(1'b1, 1'b1, DMI_SH, 32'h30, 32'h0000_1234, lat, rd, err);
    n_assert++;
    if ({lat, mem[12]} !== {32'd4, 32'h8001_1234}) begin
      n_fail++;
      $display("FAIL sh_rmw: lat=%0d word=%h, required 4 80011234", lat, mem[12]);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic err; int base_re, base_we;
    base_re = re_cnt; base_we = we_cnt;
    txn(1'b0, 1'b0, DMO_LW, 32'h13, 32'h0, lat, rd, err);
    n_assert++;
    if ({lat, rd, err} !== {32'd1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL mis_lw: lat=%0d rd=%h err=%b, required 1 00000000 1", lat, rd, err);
    end
    txn(1'b1, 1'b1, DMI_SH, 32'h11, 32'h5555, lat, rd, err);
    n_assert++;
    if ({lat, err} !== {32'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL mis_sh: lat=%0d err=%b, required 1 1", lat, err);
    end
    n_assert++;
    if ({re_cnt - base_re, we_cnt - base_we} !== 64'h0) begin
      n_fail++;
      $display("FAIL mis_no_strobe: re=%0d we=%0d, required 0 0", re_cnt - base_re, we_cnt - base_we);
    end
  endtask

  task automatic test_no_err_check();
    int t;
    preload(32'h10, 32'hCAFE_F00D);
    nc_req = 1'b1; nc_a = 32'h13;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!nc_ack0 && t < 20);
    n_assert++;
    if ({t, nc_rd0, nc_err0, nc_mem_A} !== {32'd3, 32'hCAFE_F00D, 1'b0, 32'h10}) begin
      n_fail++;
      $display("FAIL nocheck_lw: lat=%0d rd=%h err=%b mem_A=%h, required 3 cafef00d 0 00000010", t, nc_rd0, nc_err0, nc_mem_A);
    end
    n_assert++;
    if ({nc_ack1, nc_err1, nc_rd1} !== 34'h0) begin
      n_fail++;
      $display("FAIL nocheck_port1_idle: ack1=%b err1=%b rd1=%h, required 0 0 0", nc_ack1, nc_err1, nc_rd1);
    end
    nc_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    int t; int base_we, base_g;
    preload(32'h60, 32'h0102_0304);
    Req0 = 1'b1; WE0 = 1'b1; Op0 = DMI_SB; A0 = 32'h61; WD0 = 32'h55;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!mem_WE && t < 10);
    n_assert++;
    if (!mem_WE) begin n_fail++; $display("FAIL rst_reach_write: mem_WE=0 after %0d cycles, required 1", t); end
    base_we = we_cnt; base_g = glog.size();
    Reset_n = 1'b0;
    #1;
    n_assert++;
    if ({Ack0, Ack1, Err0, Err1, mem_RE, mem_WE, RD0, RD1, mem_A, mem_WD} !== 134'h0) begin
      n_fail++;
      $display("FAIL rst_async_outputs: mem_WE=%b mem_A=%h mem_WD=%h, required all outputs 0", mem_WE, mem_A, mem_WD);
    end
    Req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({mem[24], we_cnt - base_we, glog.size() - base_g} !== {32'h0102_0304, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_no_write_no_ack: word=%h writes=%0d acks=%0d, required 01020304 0 0", mem[24], we_cnt - base_we, glog.size() - base_g);
    end
    Reset_n = 1'b1;
    @(posedge clk); #1;
    Req0 = 1'b1; WE0 = 1'b0; Op0 = DMO_LW; A0 = 32'h60;
    Req1 = 1'b1; WE1 = 1'b0; Op1 = DMO_LW; A1 = 32'h20;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!Ack0 && !Ack1 && t < 20);
    n_assert++;
    if ({Ack0, Ack1, RD0} !== {1'b1, 1'b0, 32'h0102_0304}) begin
      n_fail++;
      $display("FAIL rst_first_grant: Ack0=%b Ack1=%b RD0=%h, required 1 0 01020304", Ack0, Ack1, RD0);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0; Op0 = '0; Op1 = '0;
    A0 = '0; A1 = '0; WD0 = '0; WD1 = '0;
    nc_req = 1'b0; nc_a = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    Reset_n = 1'b1;
    @(posedge clk); #1;
    test_back_to_back();
    test_sw_lw();
    test_sub_byte();
    test_halfword();
    test_misaligned();
    test_no_err_check();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
